muldiv_hilo_ctrl: RTL and testbench

Iterative multiply/divide sequencer owning the HI/LO register pair of the MIPS150 datapath. It accepts MULT/MULTU/DIV/DIVU from the execute stage and runs a 32-step shift-add multiply or restoring divide. It writes the 64-bit result into HI/LO and services MFHI/MFLO/MTHI/MTLO. While an operation is in flight it raises a stall to the pipeline so that no HI/LO access or new operation is lost.

---
 rtl/muldiv_hilo_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl
// Iterative multiply/divide sequencer that owns the HI/LO register pair.
// MULT/MULTU use a shift-add multiplier, DIV/DIVU use a restoring divider.
// Both work on operand magnitudes, and the sign is fixed up in FINISH.
// While an operation is in flight, stall holds back any HI/LO access or any
// new request so that it is re-presented once the unit returns to IDLE.

module muldiv_hilo_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             mfhi,
    input  logic             mflo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    // op[1] selects divide, op[0] selects unsigned
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        FINISH = 2'b10
    } state_t;

    state_t state;
    state_t state_nxt;

    // Latched operation context
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   opa;        // |a|: multiplicand, or dividend shifted out MSB first
    logic [WIDTH-1:0]   opb;        // |b|: multiplier shifted out LSB first, or divisor
    logic [2*WIDTH-1:0] acc;        // product, or remainder:quotient
    logic [5:0]         cnt;
    logic               neg_res;    // negate product / quotient
    logic               neg_rem;    // negate remainder
    logic               div_zero;

    // Request qualification
    logic accept;
    logic mt_ok;

    // Operand magnitudes at acceptance
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Iteration datapath
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH:0]     div_rem_sh;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_acc;

    // Sign-corrected results
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // Magnitudes and sign handling for the operands being presented
    always_comb begin
        a_neg = ~op[0] & a[WIDTH-1];
        b_neg = ~op[0] & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // One multiply step and one divide step, evaluated from the current state
    always_comb begin
        // Multiply: 33-bit add into the upper half so the carry survives the shift
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opa};
        if (opb[0]) begin
            mul_acc = {mul_sum, acc[WIDTH-1:1]};
        end else begin
            mul_acc = {1'b0, acc[2*WIDTH-1:1]};
        end

        // Divide: shift the next dividend bit into the remainder, then trial-subtract
        div_rem_sh = {acc[2*WIDTH-1:WIDTH], opa[WIDTH-1]};
        div_trial  = div_rem_sh - {1'b0, opb};
        if (div_trial[WIDTH]) begin
            div_acc = {div_rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            div_acc = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    // Final sign correction; a zero divisor keeps the all-ones quotient
    always_comb begin
        prod = neg_res ? -acc : acc;
        quo  = (neg_res && !div_zero) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic, busy/stall and request qualification
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        accept    = 1'b0;
        mt_ok     = 1'b0;
        case (state)
            IDLE: begin
                accept = start;
                mt_ok  = ~start;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST_STEP) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        stall = busy & (start | mthi | mtlo | mfhi | mflo);
    end

    // Operand capture on acceptance, then one iteration per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= OP_MULT;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else if (accept) begin
            op_q     <= op;
            opa      <= a_mag;
            opb      <= b_mag;
            acc      <= '0;
            cnt      <= '0;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= (b == '0);
        end else if (state == RUN) begin
            cnt <= cnt + 6'd1;
            if (op_q[1]) begin
                acc <= div_acc;
                opa <= {opa[WIDTH-2:0], 1'b0};
            end else begin
                acc <= mul_acc;
                opb <= {1'b0, opb[WIDTH-1:1]};
            end
        end
    end

    // HI/LO update at FINISH, or MTHI/MTLO in an idle cycle without start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == FINISH);
            if (state == FINISH) begin
                if (op_q[1]) begin
                    hi <= rem;
                    lo <= quo;
                end else begin
                    hi <= prod[2*WIDTH-1:WIDTH];
                    lo <= prod[WIDTH-1:0];
                end
            end else if (mt_ok) begin
                if (mthi) begin
                    hi <= wdata;
                end
                if (mtlo) begin
                    lo <= wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb_muldiv_hilo_ctrl
// Directed bench for muldiv_hilo_ctrl. It drives inputs on the falling edge
// and samples outputs on the falling edge too, away from the rising edge.
// Each scenario task checks its own hand-computed expected values.

module tb_muldiv_hilo_ctrl;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        mfhi;
    logic        mflo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    int compared   = 0;
    int mismatched = 0;

    muldiv_hilo_ctrl #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .mfhi  (mfhi),
        .mflo  (mflo),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done),
        .stall (stall)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present an operation in the current low phase; returns in busy cycle 1
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for the next low phase, then present an operation
    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        applyStimulus(o, x, y);
    endtask

    // Count busy cycles until the unit drops busy (bounded)
    task automatic run_to_done(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (hi !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_hi: got %h expected %h", hi, 32'h0); end
        compared++;
        if (lo !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_lo: got %h expected %h", lo, 32'h0); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        rst_n = 1'b1;
        @(negedge clk);
        // An idle unit never stalls, even with requests present
        mfhi = 1'b1;
        #1;
        compared++;
        if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_stall: got %b expected 0", stall); end
        mfhi = 1'b0;
        n = 0;
    endtask

    task automatic test_multu_max();
        int n;
        start_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_to_done(n);
        compared++;
        if (n != 33) begin mismatched++; $display("[TB] FAIL multu_busy_cycles: got %0d expected 33", n); end
        compared++;
        if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL multu_done: got %b expected 1", done); end
        compared++;
        if (hi !== 32'hFFFFFFFE) begin mismatched++; $display("[TB] FAIL multu_hi: got %h expected %h", hi, 32'hFFFFFFFE); end
        compared++;
        if (lo !== 32'h00000001) begin mismatched++; $display("[TB] FAIL multu_lo: got %h expected %h", lo, 32'h00000001); end
        @(negedge clk);
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL multu_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_mult_signed();
        int n;
        start_op(OP_MULT, 32'hFFFFFFFB, 32'd3);
        run_to_done(n);
        compared++;
        if (hi !== 32'hFFFFFFFF) begin mismatched++; $display("[TB] FAIL mult_hi: got %h expected %h", hi, 32'hFFFFFFFF); end
        compared++;
        if (lo !== 32'hFFFFFFF1) begin mismatched++; $display("[TB] FAIL mult_lo: got %h expected %h", lo, 32'hFFFFFFF1); end
    endtask

    task automatic test_divide();
        int n;
        // -7 / 2 -> q = -3, r = -1
        start_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
        run_to_done(n);
        compared++;
        if (lo !== 32'hFFFFFFFD) begin mismatched++; $display("[TB] FAIL div_lo: got %h expected %h", lo, 32'hFFFFFFFD); end
        compared++;
        if (hi !== 32'hFFFFFFFF) begin mismatched++; $display("[TB] FAIL div_hi: got %h expected %h", hi, 32'hFFFFFFFF); end
        // 7 / 2 unsigned -> q = 3, r = 1
        start_op(OP_DIVU, 32'd7, 32'd2);
        run_to_done(n);
        compared++;
        if (lo !== 32'd3) begin mismatched++; $display("[TB] FAIL divu_lo: got %h expected %h", lo, 32'd3); end
        compared++;
        if (hi !== 32'd1) begin mismatched++; $display("[TB] FAIL divu_hi: got %h expected %h", hi, 32'd1); end
    endtask

    task automatic test_div_boundaries();
        int n;
        // Unsigned divide by zero, full latency still taken
        start_op(OP_DIVU, 32'h12345678, 32'h0);
        run_to_done(n);
        compared++;
        if (n != 33) begin mismatched++; $display("[TB] FAIL divz_busy_cycles: got %0d expected 33", n); end
        compared++;
        if (lo !== 32'hFFFFFFFF) begin mismatched++; $display("[TB] FAIL divuz_lo: got %h expected %h", lo, 32'hFFFFFFFF); end
        compared++;
        if (hi !== 32'h12345678) begin mismatched++; $display("[TB] FAIL divuz_hi: got %h expected %h", hi, 32'h12345678); end
        // Signed divide by zero with a negative dividend: HI is the original a
        start_op(OP_DIV, 32'hFFFFFFF8, 32'h0);
        run_to_done(n);
        compared++;
        if (lo !== 32'hFFFFFFFF) begin mismatched++; $display("[TB] FAIL divz_lo: got %h expected %h", lo, 32'hFFFFFFFF); end
        compared++;
        if (hi !== 32'hFFFFFFF8) begin mismatched++; $display("[TB] FAIL divz_hi: got %h expected %h", hi, 32'hFFFFFFF8); end
        // Signed overflow
        start_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        run_to_done(n);
        compared++;
        if (lo !== 32'h80000000) begin mismatched++; $display("[TB] FAIL divovf_lo: got %h expected %h", lo, 32'h80000000); end
        compared++;
        if (hi !== 32'h0) begin mismatched++; $display("[TB] FAIL divovf_hi: got %h expected %h", hi, 32'h0); end
    endtask

    task automatic test_hazards();
        int n;
        // Seed HI with a known value through an idle MTHI
        @(negedge clk);
        mthi  = 1'b1;
        wdata = 32'h11111111;
        @(negedge clk);
        mthi  = 1'b0;
        compared++;
        if (hi !== 32'h11111111) begin mismatched++; $display("[TB] FAIL mthi_idle: got %h expected %h", hi, 32'h11111111); end
        // DIVU 100 / 7 -> q = 14, r = 2, with MFHI from busy cycle 5 and MTHI in cycles 10..12
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        n = 1;
        while (busy === 1'b1 && n < 100) begin
            mfhi  = (n >= 5);
            mthi  = (n >= 10 && n <= 12);
            wdata = 32'hDEADBEEF;
            #1;
            if (n >= 5) begin
                compared++;
                if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL hazard_stall_c%0d: got %b expected 1", n, stall); end
            end
            compared++;
            if (hi !== 32'h11111111) begin mismatched++; $display("[TB] FAIL hazard_hi_hold_c%0d: got %h expected %h", n, hi, 32'h11111111); end
            @(negedge clk);
            n++;
        end
        mthi = 1'b0;
        #1;
        // done cycle: MFHI still presented, reads the new value with no stall
        compared++;
        if (n != 34) begin mismatched++; $display("[TB] FAIL hazard_busy_cycles: got %0d expected 33", n - 1); end
        compared++;
        if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL hazard_done_stall: got %b expected 0", stall); end
        compared++;
        if (hi !== 32'd2) begin mismatched++; $display("[TB] FAIL hazard_hi: got %h expected %h", hi, 32'd2); end
        compared++;
        if (lo !== 32'd14) begin mismatched++; $display("[TB] FAIL hazard_lo: got %h expected %h", lo, 32'd14); end
        mfhi = 1'b0;
        // Re-present the dropped MTHI in IDLE
        @(negedge clk);
        mthi  = 1'b1;
        wdata = 32'hDEADBEEF;
        @(negedge clk);
        mthi  = 1'b0;
        compared++;
        if (hi !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL mthi_represent: got %h expected %h", hi, 32'hDEADBEEF); end
        compared++;
        if (lo !== 32'd14) begin mismatched++; $display("[TB] FAIL mthi_lo_untouched: got %h expected %h", lo, 32'd14); end
    endtask

    task automatic test_back_to_back();
        int n;
        start_op(OP_DIVU, 32'd7, 32'd2);
        run_to_done(n);
        compared++;
        if (done !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_first_done: got %b expected 1", done); end
        // Start in the done cycle
        applyStimulus(OP_MULTU, 32'd2, 32'd3);
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_busy_rise: got %b expected 1", busy); end
        run_to_done(n);
        compared++;
        if (n != 33) begin mismatched++; $display("[TB] FAIL b2b_busy_cycles: got %0d expected 33", n); end
        compared++;
        if (lo !== 32'd6) begin mismatched++; $display("[TB] FAIL b2b_lo: got %h expected %h", lo, 32'd6); end
        compared++;
        if (hi !== 32'd0) begin mismatched++; $display("[TB] FAIL b2b_hi: got %h expected %h", hi, 32'd0); end
        // start together with mtlo in IDLE: the move is dropped
        @(negedge clk);
        mtlo  = 1'b1;
        wdata = 32'hCAFEF00D;
        applyStimulus(OP_MULTU, 32'd5, 32'd5);
        mtlo  = 1'b0;
        compared++;
        if (lo !== 32'd6) begin mismatched++; $display("[TB] FAIL start_mtlo_drop: got %h expected %h", lo, 32'd6); end
        run_to_done(n);
        compared++;
        if (lo !== 32'd25) begin mismatched++; $display("[TB] FAIL start_mtlo_lo: got %h expected %h", lo, 32'd25); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        // Load both registers at once with a recognisable pattern
        @(negedge clk);
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'hA5A5A5A5;
        @(negedge clk);
        mthi  = 1'b0;
        mtlo  = 1'b0;
        compared++;
        if (hi !== 32'hA5A5A5A5) begin mismatched++; $display("[TB] FAIL mt_both_hi: got %h expected %h", hi, 32'hA5A5A5A5); end
        compared++;
        if (lo !== 32'hA5A5A5A5) begin mismatched++; $display("[TB] FAIL mt_both_lo: got %h expected %h", lo, 32'hA5A5A5A5); end
        applyStimulus(OP_MULTU, 32'd3, 32'd4);
        // After step 10 at E10
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if (hi !== 32'h0) begin mismatched++; $display("[TB] FAIL midrst_hi: got %h expected %h", hi, 32'h0); end
        compared++;
        if (lo !== 32'h0) begin mismatched++; $display("[TB] FAIL midrst_lo: got %h expected %h", lo, 32'h0); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start_op(OP_MULTU, 32'h00010000, 32'h00010000);
        run_to_done(n);
        compared++;
        if (n != 33) begin mismatched++; $display("[TB] FAIL postrst_busy_cycles: got %0d expected 33", n); end
        compared++;
        if (hi !== 32'h1) begin mismatched++; $display("[TB] FAIL postrst_hi: got %h expected %h", hi, 32'h1); end
        compared++;
        if (lo !== 32'h0) begin mismatched++; $display("[TB] FAIL postrst_lo: got %h expected %h", lo, 32'h0); end
    endtask

    // Scenario sequence
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        wdata = '0;
        mfhi  = 1'b0;
        mflo  = 1'b0;
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_divide();
        test_div_boundaries();
        test_hazards();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no completion expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
